// File: rtl/freq_meter.sv
// Counts clk_syn rising edges over GATE_LEN clk_ref cycles and reports each window with overflow and lock status.
// The report appears one cycle after the last gate cycle, and edges reach the counter 2-3 cycles after the pin; there is no backpressure.
`timescale 1ns/1ps
module freq_meter #(
  parameter int GATE_LEN  = 256,
  parameter int CNT_W     = 16,
  parameter int TOL       = 2,
  parameter int LOCK_WINS = 4
) (
  input  logic             clk_ref,
  input  logic             rst_n,
  input  logic             clk_syn,
  input  logic             enable,
  input  logic [CNT_W-1:0] expected,
  output logic [CNT_W-1:0] meas_count,
  output logic             meas_valid,
  output logic             overflow,
  output logic             locked
);

  localparam int GATE_W = $clog2(GATE_LEN);
  localparam int STRK_W = $clog2(LOCK_WINS + 1);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_LEN - 1);
  localparam logic [STRK_W-1:0] STRK_MAX  = STRK_W'(LOCK_WINS);
  localparam logic [CNT_W:0]    TOL_W     = (CNT_W + 1)'(TOL);

  typedef enum logic {IDLE, COUNT} state_t;

  state_t            state;
  logic              sync1, sync2, prev;
  logic              syn_edge;
  logic [GATE_W-1:0] gate_cnt;
  logic [CNT_W-1:0]  edge_cnt;
  logic              ovf;
  logic [STRK_W-1:0] streak;

  logic              at_max;
  logic [CNT_W-1:0]  cnt_next;
  logic              ovf_next;
  logic [CNT_W:0]    diff;
  logic              in_tol;
  logic [STRK_W-1:0] streak_inc;

  // clk_syn is asynchronous to clk_ref: two flops before it is used as data
  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= clk_syn;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign syn_edge = sync2 & ~prev;

  always_comb begin
    at_max     = (edge_cnt == {CNT_W{1'b1}});
    cnt_next   = (syn_edge && !at_max) ? edge_cnt + CNT_W'(1) : edge_cnt;
    ovf_next   = ovf | (syn_edge & at_max);
    diff       = '0;
    if ({1'b0, cnt_next} >= {1'b0, expected}) begin
      diff = {1'b0, cnt_next} - {1'b0, expected};
    end else begin
      diff = {1'b0, expected} - {1'b0, cnt_next};
    end
    in_tol     = !ovf_next && (diff <= TOL_W);
    streak_inc = (streak == STRK_MAX) ? streak : streak + STRK_W'(1);
  end

  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      ovf        <= 1'b0;
      streak     <= '0;
      meas_count <= '0;
      meas_valid <= 1'b0;
      overflow   <= 1'b0;
      locked     <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      case (state)
        IDLE: begin
          gate_cnt <= '0;
          edge_cnt <= '0;
          ovf      <= 1'b0;
          if (enable) state <= COUNT;
        end
        COUNT: begin
          if (!enable) begin
            // partial window is dropped; lock history no longer applies
            state    <= IDLE;
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf      <= 1'b0;
            streak   <= '0;
            locked   <= 1'b0;
          end else if (gate_cnt == GATE_LAST) begin
            meas_count <= cnt_next;
            overflow   <= ovf_next;
            meas_valid <= 1'b1;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            ovf        <= 1'b0;
            if (in_tol) begin
              streak <= streak_inc;
              locked <= (streak_inc == STRK_MAX);
            end else begin
              streak <= '0;
              locked <= 1'b0;
            end
          end else begin
            gate_cnt <= gate_cnt + GATE_W'(1);
            edge_cnt <= cnt_next;
            ovf      <= ovf_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Scoreboarded bench for freq_meter: a 16-bit instance for counting, lock, abort and reset, and a 6-bit instance for saturation.
`timescale 1ns/1ps
module tb_freq_meter;

  typedef struct {
    logic        chk_cnt;
    logic [15:0] cnt;
    logic        ovf;
    logic        lck;
    int          at;
  } exp_t;

  logic        clk_ref;
  logic        rst_n;
  logic        clk_syn;
  logic        enable, enable2;
  logic [15:0] expected;
  logic [5:0]  expected2;
  logic [15:0] meas_count1;
  logic        meas_valid1, overflow1, locked1;
  logic [5:0]  meas_count2;
  logic        meas_valid2, overflow2, locked2;

  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  int   syn_mode = 2;
  int   base;
  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;

  freq_meter #(.GATE_LEN(256), .CNT_W(16), .TOL(2), .LOCK_WINS(4)) dut1 (
    .clk_ref(clk_ref), .rst_n(rst_n), .clk_syn(clk_syn), .enable(enable),
    .expected(expected), .meas_count(meas_count1), .meas_valid(meas_valid1),
    .overflow(overflow1), .locked(locked1)
  );

  freq_meter #(.GATE_LEN(256), .CNT_W(6), .TOL(2), .LOCK_WINS(4)) dut2 (
    .clk_ref(clk_ref), .rst_n(rst_n), .clk_syn(clk_syn), .enable(enable2),
    .expected(expected2), .meas_count(meas_count2), .meas_valid(meas_valid2),
    .overflow(overflow2), .locked(locked2)
  );

  initial begin
    clk_ref = 1'b0;
    forever #5 clk_ref = ~clk_ref;
  end

  always @(posedge clk_ref) cyc <= cyc + 1;

  // clk_syn changes 3 ns after each clk_ref rise: 0 = low, 1 = high, 2 = toggle
  initial begin
    clk_syn = 1'b0;
    forever begin
      @(posedge clk_ref);
      #3;
      case (syn_mode)
        0:       clk_syn = 1'b0;
        1:       clk_syn = 1'b1;
        default: clk_syn = ~clk_syn;
      endcase
    end
  end

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
  endtask

  task automatic push1(input logic c, input logic [15:0] v, input logic o, input logic l, input int at);
    exp_t e;
    e.chk_cnt = c; e.cnt = v; e.ovf = o; e.lck = l; e.at = at;
    q1.push_back(e);
  endtask

  task automatic push2(input int at);
    exp_t e;
    e.chk_cnt = 1'b1; e.cnt = 16'd63; e.ovf = 1'b1; e.lck = 1'b0; e.at = at;
    q2.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_ref);
  endtask

  always @(negedge clk_ref) begin
    if (meas_valid1) begin
      chk("d1_report_expected", q1.size() > 0, 1);
      if (q1.size() > 0) begin
        e1 = q1.pop_front();
        if (e1.chk_cnt) chk("d1_meas_count", meas_count1, e1.cnt);
        chk("d1_overflow", overflow1, e1.ovf);
        chk("d1_locked", locked1, e1.lck);
        chk("d1_valid_cycle", cyc, e1.at);
      end
    end
  end

  always @(negedge clk_ref) begin
    if (meas_valid2) begin
      chk("d2_report_expected", q2.size() > 0, 1);
      if (q2.size() > 0) begin
        e2 = q2.pop_front();
        chk("d2_meas_count", meas_count2, e2.cnt);
        chk("d2_overflow", overflow2, e2.ovf);
        chk("d2_locked", locked2, e2.lck);
        chk("d2_valid_cycle", cyc, e2.at);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; enable2 = 1'b0;
    expected = 16'd128; expected2 = 6'd63;
    wait_cyc(3);
    chk("rst_meas_count", meas_count1, 0);
    chk("rst_locked", locked1, 0);
    chk("rst_valid", meas_valid1, 0);
    wait_cyc(2);

    // steady toggle: 128 edges per window; lock after 4, lose at expected=140, regain at 129
    rst_n = 1'b1; enable = 1'b1; enable2 = 1'b1; base = cyc;
    for (int k = 0; k < 9; k++) begin
      push1(k != 0, 16'd128, 1'b0, (k == 3) || (k == 8), base + 257 + 256 * k);
      push2(base + 257 + 256 * k);
    end
    wait_cyc(257 + 256 * 3);
    expected = 16'd140;
    wait_cyc(256);
    expected = 16'd129;
    wait_cyc(256 * 4);

    // asynchronous reset at gate cycle 100 while locked and holding counts
    wait_cyc(100);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_meas_count", meas_count1, 0);
    chk("async_rst_locked", locked1, 0);
    chk("async_rst_overflow2", overflow2, 0);
    chk("async_rst_meas_count2", meas_count2, 0);
    @(negedge clk_ref);
    rst_n = 1'b1; base = cyc;
    for (int k = 0; k < 4; k++) begin
      push1(k != 0, 16'd128, 1'b0, k == 3, base + 257 + 256 * k);
      push2(base + 257 + 256 * k);
    end
    wait_cyc(257 + 256 * 3 + 100);

    // abort at gate cycle 100
    enable = 1'b0; enable2 = 1'b0;
    wait_cyc(1);
    chk("abort_locked", locked1, 0);
    chk("abort_meas_count_hold", meas_count1, 128);
    chk("abort_overflow_hold", overflow1, 0);
    chk("abort_meas_count2_hold", meas_count2, 63);
    chk("abort_overflow2_hold", overflow2, 1);
    wait_cyc(50);

    // re-enable: full window later; drop enable in the report cycle
    enable = 1'b1; base = cyc;
    push1(1'b1, 16'd128, 1'b0, 1'b0, base + 257);
    wait_cyc(257);
    enable = 1'b0;
    wait_cyc(1);
    chk("late_abort_locked", locked1, 0);
    chk("late_abort_meas_count", meas_count1, 128);

    // static clk_syn low, then high (single edge)
    syn_mode = 0;
    wait_cyc(10);
    expected = 16'd128; enable = 1'b1; base = cyc;
    for (int k = 0; k < 3; k++) push1(1'b1, 16'd0, 1'b0, 1'b0, base + 257 + 256 * k);
    wait_cyc(257 + 512);
    syn_mode = 1; base = cyc;
    push1(1'b1, 16'd1, 1'b0, 1'b0, base + 256);
    push1(1'b1, 16'd0, 1'b0, 1'b0, base + 512);
    push1(1'b1, 16'd0, 1'b0, 1'b0, base + 768);
    wait_cyc(768);
    enable = 1'b0;
    wait_cyc(5);

    chk("d1_reports_outstanding", q1.size(), 0);
    chk("d2_reports_outstanding", q2.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Downstream monitor for the frequency synthesizer output.
- Samples clk_syn as a data signal in the clk_ref domain and counts its rising edges over a fixed gate window of clk_ref cycles.
- Reports one count per window, together with an overflow flag and a lock indication against an expected count.
- Used for closed-loop checking of the synthesizer's ctrl setting.

Parameters:
- GATE_LEN, 256, clk_ref cycles per measurement window (>=4).
- CNT_W, 16, width of the edge count and of expected.
- TOL, 2, allowed absolute difference |count - expected| for a window to be "in tolerance".
- LOCK_WINS, 4, consecutive in-tolerance windows required to assert locked (>=1).

Ports:
- clk_ref  in  1  reference clock; all logic runs on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clk_syn  in  1  synthesized clock, treated as asynchronous data.
- enable  in  1  1 = measure continuously; 0 = idle.
- expected  in  CNT_W  target edges per window; sampled at window end.
- meas_count  out  CNT_W  last completed window's edge count; held between updates.
- meas_valid  out  1  one-cycle pulse when meas_count/overflow update.
- overflow  out  1  last window saturated; updates with meas_valid.
- locked  out  1  lock indication.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs 0.
  - Synchronizer, edge register, counters and streak counter 0.
  - State IDLE.
  - Applies immediately, including mid-window.
- Input path, always running:
  - 2-flop synchronizer, then a previous-value register.
  - edge = sync2 & ~prev.
  - Latency from a clk_syn rise to edge is 2-3 clk_ref cycles.
  - clk_syn held high through reset release yields one edge after release; this is permitted.
- State IDLE:
  - gate_cnt = 0, edge_cnt = 0, edges ignored.
  - enable=1 moves to COUNT on the next cycle.
- State COUNT:
  - gate_cnt increments 0..GATE_LEN-1 each cycle.
  - edge_cnt increments on edge and saturates at 2^CNT_W-1; saturation sets an internal ovf flag.
  - Last cycle (gate_cnt==GATE_LEN-1): an edge in that cycle belongs to the current window.
  - Next cycle: meas_count = final count, overflow = ovf, meas_valid = 1.
  - In that same cycle gate_cnt and edge_cnt restart from 0 for the next window. Windows are back-to-back with no dead cycle; an edge in that cycle counts in the new window.
- enable=0 in COUNT:
  - Next cycle: return to IDLE, discard the partial window, no meas_valid.
  - locked=0 and streak=0; meas_count and overflow hold.
  - If enable falls in the cycle after the last gate cycle, the completed window still reports.
- Lock, evaluated only at meas_valid:
  - A window is in tolerance iff overflow==0 and |final_count - expected| <= TOL, computed in CNT_W+1 bits, no wrap.
  - In tolerance: streak increments, saturating at LOCK_WINS. locked=1 in the same cycle as the meas_valid that makes streak==LOCK_WINS.
  - Out of tolerance: streak=0 and locked=0 in the same cycle as that meas_valid.
- expected may change at any time; only its value in the window-end cycle matters.

Test Plan:
- Reset mid-window: enable=1, clk_syn toggling; pull rst_n low at cycle 100 -> all outputs 0 asynchronously. Release -> the first report arrives no earlier than GATE_LEN cycles after COUNT entry.
- Steady count: GATE_LEN=256, clk_syn toggled every clk_ref cycle, enable=1 -> meas_valid exactly every 256 cycles, single-cycle. Windows 2 and later give meas_count=128, overflow=0.
- Lock: expected=128, TOL=2, LOCK_WINS=4 -> locked rises with the 4th meas_valid. Change expected to 140 -> locked falls with the next meas_valid. Back to 129 -> locked reasserts after 4 more windows.
- Overflow: CNT_W=6, same stimulus, expected=63 -> meas_count=63, overflow=1 every window, locked stays 0.
- Abort: deassert enable at gate cycle 100 -> no meas_valid, locked=0, meas_count holds its prior value. Re-enable -> the next meas_valid comes a full GATE_LEN window later.
- Static input: clk_syn held 0 (also held 1) -> meas_count=0 from the second window on; with expected=128, locked=0.
